// File: rtl/ch_scheduler_pkg.sv
// Shared constants, FSM encoding and helpers for the three-channel read scheduler.
package ch_scheduler_pkg;

    localparam int BUFF_SIZE_DFLT = 8;
    localparam int CH_NUM         = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Channel number 1..3 to one-hot read strobe vector (bit 0 = channel 1).
    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        logic [2:0] oh;
        case (ch)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ch_scheduler_rr_pick.sv
// Combinational 3-way round-robin picker: first eligible channel after 'last'.
module rr_pick (
    input  logic [2:0] eligible,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] win
);
    import ch_scheduler_pkg::*;

    // Search order starts one past the previous grant and wraps around.
    always_comb begin
        win   = 2'd0;
        valid = |eligible;
        case (last)
            2'd1: begin
                if (eligible[1])      win = 2'd2;
                else if (eligible[2]) win = 2'd3;
                else if (eligible[0]) win = 2'd1;
                else                  win = 2'd0;
            end
            2'd2: begin
                if (eligible[2])      win = 2'd3;
                else if (eligible[0]) win = 2'd1;
                else if (eligible[1]) win = 2'd2;
                else                  win = 2'd0;
            end
            default: begin
                if (eligible[0])      win = 2'd1;
                else if (eligible[1]) win = 2'd2;
                else if (eligible[2]) win = 2'd3;
                else                  win = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/ch_scheduler.sv
// Three-channel round-robin FIFO read scheduler with starvation timers.
module ch_scheduler #(
    parameter int BUFF_SIZE = ch_scheduler_pkg::BUFF_SIZE_DFLT,
    parameter int BURST_LEN = 4,
    parameter int THRESH    = 4,
    parameter int AGE_MAX   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUFF_SIZE-1:0] f1_bf_cnt,
    input  logic [BUFF_SIZE-1:0] f2_bf_cnt,
    input  logic [BUFF_SIZE-1:0] f3_bf_cnt,
    input  logic                 tx_busy,
    output logic                 rd_en_fifo_1,
    output logic                 rd_en_fifo_2,
    output logic                 rd_en_fifo_3,
    output logic [1:0]           rdy_cnl,
    output logic                 burst_start,
    output logic                 burst_end,
    output logic                 sched_busy
);
    import ch_scheduler_pkg::*;

    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam int LEN_W = $clog2(BURST_LEN + 1);
    localparam logic [BUFF_SIZE-1:0] THRESH_C  = BUFF_SIZE'(THRESH);
    localparam logic [BUFF_SIZE-1:0] BURST_C   = BUFF_SIZE'(BURST_LEN);
    localparam logic [AGE_W-1:0]     AGE_MAX_C = AGE_W'(AGE_MAX);
    localparam logic [LEN_W-1:0]     LEN_MAX_C = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0]     LEN_ONE_C = LEN_W'(1);

    state_t               state_r, state_nxt_s;
    logic [1:0]           grant_r, grant_nxt_s;
    logic [1:0]           last_grant_r, last_grant_nxt_s;
    logic [LEN_W-1:0]     len_r, len_nxt_s, win_len_s;
    logic [AGE_W-1:0]     age_r [CH_NUM];
    logic [AGE_W-1:0]     age_nxt_s [CH_NUM];
    logic [BUFF_SIZE-1:0] cnt_s [CH_NUM];
    logic [BUFF_SIZE-1:0] win_cnt_s;
    logic [2:0]           elig_s;
    logic                 pick_valid_s;
    logic [1:0]           pick_win_s;
    logic                 issue_s;
    logic [2:0]           rd_en_r, rd_en_nxt_s;
    logic [1:0]           rdy_cnl_r, rdy_cnl_nxt_s;
    logic                 burst_start_r, burst_start_nxt_s;
    logic                 burst_end_r, burst_end_nxt_s;
    logic                 sched_busy_r, sched_busy_nxt_s;

    assign cnt_s[0] = f1_bf_cnt;
    assign cnt_s[1] = f2_bf_cnt;
    assign cnt_s[2] = f3_bf_cnt;

    // A channel is eligible with a full burst waiting or when it has starved long enough.
    always_comb begin
        elig_s = 3'b000;
        for (int i = 0; i < CH_NUM; i++) begin
            elig_s[i] = (cnt_s[i] >= THRESH_C) ||
                        ((cnt_s[i] != {BUFF_SIZE{1'b0}}) && (age_r[i] >= AGE_MAX_C));
        end
    end

    rr_pick u_rr_pick (
        .eligible (elig_s),
        .last     (last_grant_r),
        .valid    (pick_valid_s),
        .win      (pick_win_s)
    );

    // Burst length for the winner: never more words than the FIFO currently holds.
    always_comb begin
        case (pick_win_s)
            2'd1:    win_cnt_s = cnt_s[0];
            2'd2:    win_cnt_s = cnt_s[1];
            2'd3:    win_cnt_s = cnt_s[2];
            default: win_cnt_s = {BUFF_SIZE{1'b0}};
        endcase
        if (win_cnt_s < BURST_C) begin
            win_len_s = LEN_W'(win_cnt_s);
        end else begin
            win_len_s = LEN_MAX_C;
        end
    end

    // Starvation timers: the granted channel freezes during its burst, others keep ageing.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            if (((state_r == ST_READ) || (state_r == ST_DONE)) && (grant_r == 2'(i + 1))) begin
                age_nxt_s[i] = age_r[i];
            end else if (cnt_s[i] == {BUFF_SIZE{1'b0}}) begin
                age_nxt_s[i] = {AGE_W{1'b0}};
            end else if ((state_r == ST_ARB) && pick_valid_s && (pick_win_s == 2'(i + 1))) begin
                age_nxt_s[i] = {AGE_W{1'b0}};
            end else if (age_r[i] < AGE_MAX_C) begin
                age_nxt_s[i] = age_r[i] + AGE_W'(1);
            end else begin
                age_nxt_s[i] = age_r[i];
            end
        end
    end

    // Next state and next registered outputs; a read is issued one cycle ahead of its strobe.
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        last_grant_nxt_s  = last_grant_r;
        len_nxt_s         = len_r;
        issue_s           = 1'b0;
        rdy_cnl_nxt_s     = 2'd0;
        burst_start_nxt_s = 1'b0;
        burst_end_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_ARB;
                else       state_nxt_s = ST_IDLE;
            end
            ST_ARB: begin
                if (pick_valid_s) begin
                    grant_nxt_s       = pick_win_s;
                    issue_s           = ~tx_busy;
                    len_nxt_s         = tx_busy ? win_len_s : (win_len_s - LEN_ONE_C);
                    rdy_cnl_nxt_s     = pick_win_s;
                    burst_start_nxt_s = 1'b1;
                    state_nxt_s       = ST_READ;
                end else if (start) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                rdy_cnl_nxt_s = grant_r;
                if (len_r != {LEN_W{1'b0}}) begin
                    state_nxt_s = ST_READ;
                    if (!tx_busy) begin
                        issue_s   = 1'b1;
                        len_nxt_s = len_r - LEN_ONE_C;
                    end else begin
                        issue_s   = 1'b0;
                    end
                end else begin
                    burst_end_nxt_s = 1'b1;
                    state_nxt_s     = ST_DONE;
                end
            end
            ST_DONE: begin
                last_grant_nxt_s = grant_r;
                if (start) state_nxt_s = ST_ARB;
                else       state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        rd_en_nxt_s      = issue_s ? ch_onehot(grant_nxt_s) : 3'b000;
        sched_busy_nxt_s = (state_nxt_s == ST_READ) || (state_nxt_s == ST_DONE);
    end

    // State, counters and registered outputs; reset drops any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            grant_r       <= 2'd0;
            last_grant_r  <= 2'd3;
            len_r         <= {LEN_W{1'b0}};
            rd_en_r       <= 3'b000;
            rdy_cnl_r     <= 2'd0;
            burst_start_r <= 1'b0;
            burst_end_r   <= 1'b0;
            sched_busy_r  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) age_r[i] <= {AGE_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            len_r         <= len_nxt_s;
            rd_en_r       <= rd_en_nxt_s;
            rdy_cnl_r     <= rdy_cnl_nxt_s;
            burst_start_r <= burst_start_nxt_s;
            burst_end_r   <= burst_end_nxt_s;
            sched_busy_r  <= sched_busy_nxt_s;
            for (int i = 0; i < CH_NUM; i++) age_r[i] <= age_nxt_s[i];
        end
    end

    assign rd_en_fifo_1 = rd_en_r[0];
    assign rd_en_fifo_2 = rd_en_r[1];
    assign rd_en_fifo_3 = rd_en_r[2];
    assign rdy_cnl      = rdy_cnl_r;
    assign burst_start  = burst_start_r;
    assign burst_end    = burst_end_r;
    assign sched_busy   = sched_busy_r;

endmodule

// File: tb/tb_ch_scheduler.sv
// Directed self-checking bench for ch_scheduler (AGE_MAX shortened to 16).
module tb_ch_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] f1 = 8'd0, f2 = 8'd0, f3 = 8'd0;
    logic       rd1, rd2, rd3;
    logic [1:0] rdy_cnl;
    logic       burst_start, burst_end, sched_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cnt [3];
    logic hold_cnt = 1'b0;

    ch_scheduler #(.BUFF_SIZE(8), .BURST_LEN(4), .THRESH(4), .AGE_MAX(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .f1_bf_cnt    (f1),
        .f2_bf_cnt    (f2),
        .f3_bf_cnt    (f3),
        .tx_busy      (tx_busy),
        .rd_en_fifo_1 (rd1),
        .rd_en_fifo_2 (rd2),
        .rd_en_fifo_3 (rd3),
        .rdy_cnl      (rdy_cnl),
        .burst_start  (burst_start),
        .burst_end    (burst_end),
        .sched_busy   (sched_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and model FIFO draining by the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd1) rd_cnt[0]++;
        if (rd2) rd_cnt[1]++;
        if (rd3) rd_cnt[2]++;
        if (!hold_cnt) begin
            if (rd1) f1 = f1 - 8'd1;
            if (rd2) f2 = f2 - 8'd1;
            if (rd3) f3 = f3 - 8'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tx_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
    endtask

    function automatic logic [6:0] outs();
        return {rd1, rd2, rd3, burst_start, burst_end, sched_busy, |rdy_cnl};
    endfunction

    // Bounded wait for the next burst_start; returns 0 channel on timeout.
    task automatic wait_bs(input int budget, output logic [1:0] ch, output int at);
        ch = 2'd0; at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (burst_start) begin
                ch = rdy_cnl; at = cyc;
                break;
            end
        end
    endtask

    logic [1:0] ch;
    int at, prev_at, first_rd;

    initial begin
        // Reset state
        f1 = 8'd0; f2 = 8'd0; f3 = 8'd0;
        do_reset();
        chk("reset_outs", 32'(outs()), 32'd0);

        // Counts 5/0/0: four reads of channel 1, best-case latency two cycles
        f1 = 8'd5; start = 1'b1;
        tick();
        chk("t1_arb_no_rd", 32'(rd1), 32'd0);
        tick();
        chk("t1_rd1_c1", 32'(rd1), 32'd1);
        chk("t1_rdy", 32'(rdy_cnl), 32'd1);
        chk("t1_bstart", 32'(burst_start), 32'd1);
        chk("t1_busy", 32'(sched_busy), 32'd1);
        tick(); tick(); tick();
        chk("t1_rd1_c4", 32'(rd1), 32'd1);
        chk("t1_bstart_low", 32'(burst_start), 32'd0);
        tick();
        chk("t1_done_rd", 32'(rd1), 32'd0);
        chk("t1_bend", 32'(burst_end), 32'd1);
        chk("t1_done_rdy", 32'(rdy_cnl), 32'd1);
        chk("t1_done_busy", 32'(sched_busy), 32'd1);
        tick();
        chk("t1_arb_outs", 32'(outs()), 32'd0);
        chk("t1_reads", 32'(rd_cnt[0]), 32'd4);
        chk("t1_f1_left", 32'(f1), 32'd1);

        // Counts 8/8/8 held: round-robin 1,2,3,1 with a 6-cycle grant period
        f1 = 8'd8; f2 = 8'd8; f3 = 8'd8; hold_cnt = 1'b1;
        do_reset();
        start = 1'b1;
        wait_bs(10, ch, at);
        chk("t2_g0", 32'(ch), 32'd1);
        prev_at = at;
        wait_bs(10, ch, at);
        chk("t2_g1", 32'(ch), 32'd2);
        chk("t2_period", 32'(at - prev_at), 32'd6);
        wait_bs(10, ch, at);
        chk("t2_g2", 32'(ch), 32'd3);
        wait_bs(10, ch, at);
        chk("t2_g3", 32'(ch), 32'd1);

        // Channel 2 holds 2 words: served only after ageing, with a 2-word burst
        hold_cnt = 1'b0;
        f1 = 8'd0; f2 = 8'd0; f3 = 8'd0;
        do_reset();
        f2 = 8'd2; start = 1'b1;
        first_rd = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rd2 && first_rd < 0) first_rd = cyc;
        end
        chk("t3_first_rd", 32'(first_rd), 32'd17);
        chk("t3_reads", 32'(rd_cnt[1]), 32'd2);
        chk("t3_other_reads", 32'(rd_cnt[0] + rd_cnt[2]), 32'd0);

        // tx_busy for 3 cycles during the 2nd read: strobes drop one cycle later
        f1 = 8'd8; f2 = 8'd0; f3 = 8'd0; hold_cnt = 1'b1;
        do_reset();
        start = 1'b1;
        wait_bs(10, ch, at);
        chk("t4_g", 32'(ch), 32'd1);
        tick();
        chk("t4_rd2", 32'(rd1), 32'd1);
        tx_busy = 1'b1;
        tick(); chk("t4_stall_a", 32'(rd1), 32'd0);
        tick(); chk("t4_stall_b", 32'(rd1), 32'd0);
        tick(); chk("t4_stall_c", 32'(rd1), 32'd0);
        chk("t4_stall_busy", 32'(sched_busy), 32'd1);
        tx_busy = 1'b0;
        tick(); chk("t4_rd3", 32'(rd1), 32'd1);
        tick(); chk("t4_rd4", 32'(rd1), 32'd1);
        tick(); chk("t4_bend", 32'(burst_end), 32'd1);
        chk("t4_reads", 32'(rd_cnt[0]), 32'd4);

        // start drops mid-burst: burst completes, then IDLE with no further reads
        do_reset();
        start = 1'b1;
        wait_bs(10, ch, at);
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t5_rd4", 32'(rd1), 32'd1);
        tick();
        chk("t5_bend", 32'(burst_end), 32'd1);
        for (int k = 0; k < 10; k++) tick();
        chk("t5_idle_outs", 32'(outs()), 32'd0);
        chk("t5_reads", 32'(rd_cnt[0]), 32'd4);

        // Reset during channel 2 burst: outputs clear, channel 1 first again
        f1 = 8'd8; f2 = 8'd8; f3 = 8'd8;
        do_reset();
        start = 1'b1;
        wait_bs(10, ch, at);
        wait_bs(10, ch, at);
        chk("t6_g2", 32'(ch), 32'd2);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        wait_bs(10, ch, at);
        chk("t6_after_rst", 32'(ch), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ch_scheduler.md
# ch_scheduler

Three-channel read scheduler between the input FIFOs and the packet former. It watches the fill counts of FIFO 1..3 and grants the shared read path to one channel at a time in round-robin order. A starvation timer guarantees service for a channel that holds fewer than a full burst of words. It issues per-channel read enables for one burst and reports the active channel to the packet former, throttled by transmitter `tx_busy`.

## Interface
Parameters:
- `BUFF_SIZE`, default `` `BUFF_SIZE `` (8): width of the FIFO fill counts.
- `BURST_LEN`, default 4: maximum words read per grant; must be ≥1.
- `THRESH`, default 4: fill level at which a channel becomes eligible; must be ≥1.
- `AGE_MAX`, default 255: wait cycles after which a non-empty channel below `THRESH` becomes eligible.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level enable for scheduling.
- `f1_bf_cnt`, `f2_bf_cnt`, `f3_bf_cnt`  in  BUFF_SIZE  FIFO fill counts.
- `tx_busy`  in  1  transmitter busy; stalls reads.
- `rd_en_fifo_1`, `rd_en_fifo_2`, `rd_en_fifo_3`  out  1  FIFO read strobes; at most one is high per cycle.
- `rdy_cnl`  out  2  granted channel 1..3; 0 when no channel is granted.
- `burst_start`  out  1  one-cycle pulse on the first READ cycle.
- `burst_end`  out  1  one-cycle pulse in DONE.
- `sched_busy`  out  1  high in READ and DONE.

## Operation
- States: IDLE, ARB, READ, DONE.
- IDLE → ARB when `start`=1.
- ARB, eligibility: channel i is eligible when `cnt_i ≥ THRESH`, or when `cnt_i ≠ 0` and `age_i ≥ AGE_MAX`.
- ARB, selection: the first eligible channel in order last_grant+1, +2, +3 (mod 3) wins.
- ARB, on a win:
  - latch `grant`.
  - latch `len = min(cnt_grant, BURST_LEN)`; fill counts are sampled only in ARB.
  - go to READ.
- ARB, with nothing eligible: stay in ARB if `start`=1, otherwise go to IDLE.
- READ:
  - each cycle with `tx_busy`=0, assert the granted `rd_en` and decrement `len`.
  - with `tx_busy`=1, all `rd_en` are low and `len` holds.
  - after the read where `len` reaches 0, go to DONE.
- DONE: pulse `burst_end` and set `last_grant ← grant`. Go to ARB if `start`=1, otherwise IDLE.
- `start` falling mid-burst: the burst completes; the fall takes effect at DONE.
- Age counters, per channel, width `$clog2(AGE_MAX+1)`:
  - clear when the count is 0, or when the channel is granted in ARB.
  - otherwise increment, saturating at `AGE_MAX`.
  - hold while that channel is in READ/DONE.
- `last_grant` resets to channel 3, so channel 1 has first priority.
- FIFO counts only grow except through this block's reads. `len ≤ cnt` therefore guarantees no read of an empty FIFO.
- Reset mid-burst: everything returns to IDLE at the reset edge and all `rd_en` are low in the next cycle. No partial-burst state is retained.

## Timing
- Reset values: `rd_en_fifo_*`=0, `rdy_cnl`=0, `burst_start`=0, `burst_end`=0, `sched_busy`=0; ages=0; `last_grant`=3.
- All outputs are registered.
- Latency from ARB with a winner to the first `rd_en`: 1 cycle. Best case from `start` rising: 2 cycles.
- The `tx_busy` sampled in cycle n gates `rd_en` in cycle n+1.
- `rdy_cnl` is valid from the first READ cycle through DONE.
- Unstalled burst of L words: L READ cycles + 1 DONE + 1 ARB. A grant-to-grant period is L+2 cycles.
- Simultaneous eligibility is resolved purely by round-robin order. Age has no priority weight beyond eligibility.

## Structure
- Shared constants `BUFF_SIZE`, `CH_NUM` and the state encodings `ST_IDLE`, `ST_ARB`, `ST_READ`, `ST_DONE` belong in params.vh.
- One sub-module, `rr_pick`: combinational 3-way round-robin priority picker.
  - inputs: `eligible[2:0]`, `last[1:0]`.
  - outputs: `valid`, `win[1:0]`.
- FSM, `len` counter and age counters live in `ch_scheduler`.

## Test plan
- Reset, then `start`=1 with counts 5/0/0 → `rd_en_fifo_1` high for 4 consecutive cycles with `rdy_cnl`=1; `burst_start` on the 1st read cycle, `burst_end` on the cycle after the 4th read.
- Counts 8/8/8 held, `start`=1 → bursts granted in channel order 1, 2, 3, 1.
- Channel 2 count = 2, others 0, `AGE_MAX`=16 → no grant for 16 cycles, then exactly 2 reads on `rd_en_fifo_2`; `len` is not `BURST_LEN`.
- `tx_busy` high for 3 cycles during the 2nd read of a 4-word burst → `rd_en` low for exactly those 3 cycles (one cycle lag), total reads still 4.
- `start` drops during READ → burst completes, then IDLE; `rdy_cnl`=0 and no further `rd_en`.
- `rst` asserted during READ → next cycle all outputs 0; after release, channel 1 has first priority again.
